windowed_mean: RTL and testbench

- Parametrised successor of the fixed-width period mean stage in the RMS finder chain.
- Accepts a stream of squared samples with a valid qualifier and sums a programmable number of samples (a window).
- At each window end, divides the sum by the window length in a sequential divider and presents the mean with a one-cycle valid strobe.
- Accumulation of the next window continues while the divider runs. Feeds the square-root stage.

---
 rtl/mean_pkg.sv | 21 ++
 rtl/seq_divider.sv | 85 ++++++++
 rtl/windowed_mean.sv | 122 ++++++++++++
 tb/tb_windowed_mean.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mean_pkg.sv
// Shared constants, divider state encoding and iteration-count helper for windowed_mean.
// Optional build macro WINDOWED_MEAN_ROUND_EN (see windowed_mean.sv) widens the divider by one bit.
package mean_pkg;

  localparam int unsigned MEAN_IN_W  = 32;
  localparam int unsigned MEAN_LEN_W = 16;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Restoring divider retires one quotient bit per iteration, so iterations == dividend width.
  function automatic int unsigned div_iters(input int unsigned in_w,
                                            input int unsigned len_w,
                                            input int unsigned round_en);
    return in_w + len_w + round_en;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async active-low), clear (sync abort), start (load operands when idle or done),
//        dividend[WIDTH], divisor[DVS_W], quotient[Q_W] (low bits of the full quotient),
//        done (high in the single DONE cycle), busy (RUN or DONE).
module seq_divider
  import mean_pkg::*;
#(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DVS_W = 16,
  parameter int unsigned Q_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shift_c;
  logic [WIDTH:0]   diff_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and iteration logic; diff_c[WIDTH] set means the trial subtraction borrowed
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shift_c = {rem_q, quo_q[WIDTH-1]};
    diff_c  = shift_c - (WIDTH+1)'(dvs_q);
    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (start) begin
          rem_d   = '0;
          quo_d   = dividend;
          dvs_d   = divisor;
          cnt_d   = CNT_W'(WIDTH);
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        rem_d = diff_c[WIDTH] ? shift_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff_c[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DIV_DONE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (clear) state_d = DIV_IDLE;
  end

  assign quotient = quo_q[Q_W-1:0];
  assign done     = (state_q == DIV_DONE);
  assign busy     = (state_q != DIV_IDLE);

endmodule

// File: rtl/windowed_mean.sv
// Windowed mean of a squared-sample stream: sums `period` valid samples, then divides the
// sum by the window length in a sequential divider while the next window accumulates.
// Ports: clk, rst_n (async active-low), clear (sync abort), period[LEN_W], in_valid,
//        in_data[IN_W] -> mean[IN_W] (held), mean_valid (pulse), busy (divider active),
//        missed (pulse when a finished window finds the divider busy).
// Build macro WINDOWED_MEAN_ROUND_EN: round-half-up (adds len/2 to the dividend, +1 latency).
module windowed_mean
  import mean_pkg::*;
#(
  parameter int unsigned IN_W  = MEAN_IN_W,
  parameter int unsigned LEN_W = MEAN_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [LEN_W-1:0] period,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  mean,
  output logic             mean_valid,
  output logic             busy,
  output logic             missed
);

  localparam int unsigned ACC_W = IN_W + LEN_W;
`ifdef WINDOWED_MEAN_ROUND_EN
  localparam int unsigned RND_EN = 1;
`else
  localparam int unsigned RND_EN = 0;
`endif
  localparam int unsigned DIV_W = div_iters(IN_W, LEN_W, RND_EN);

  logic [ACC_W-1:0] sum;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_q;

  logic             start_c;
  logic [LEN_W-1:0] eff_len_c;
  logic             take_c;
  logic [LEN_W-1:0] count_inc_c;
  logic             win_end_c;
  logic [ACC_W-1:0] sum_next_c;
  logic             div_ready_c;
  logic             div_start_c;
  logic [DIV_W-1:0] dividend_c;
  logic [IN_W-1:0]  quotient;
  logic             div_done;
  logic             div_busy;

  // Window bookkeeping; an empty window (count==0) means the next sample opens one
  always_comb begin
    start_c     = (count == '0);
    eff_len_c   = start_c ? period : len_q;
    take_c      = in_valid && !(start_c && (period == '0));
    count_inc_c = count + LEN_W'(1);
    win_end_c   = take_c && (count_inc_c == eff_len_c);
    sum_next_c  = sum + ACC_W'(in_data);
    // The divider can take a new load on the same edge it leaves DONE
    div_ready_c = !div_busy || div_done;
    div_start_c = win_end_c && div_ready_c && !clear;
`ifdef WINDOWED_MEAN_ROUND_EN
    dividend_c  = DIV_W'(sum_next_c) + DIV_W'(eff_len_c >> 1);
`else
    dividend_c  = DIV_W'(sum_next_c);
`endif
  end

  // Accumulator, window length latch and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      count      <= '0;
      len_q      <= '0;
      mean       <= '0;
      mean_valid <= 1'b0;
      missed     <= 1'b0;
    end else begin
      mean_valid <= 1'b0;
      missed     <= 1'b0;
      if (clear) begin
        sum   <= '0;
        count <= '0;
        len_q <= '0;
      end else begin
        if (take_c) begin
          if (start_c) len_q <= period;
          if (win_end_c) begin
            sum   <= '0;
            count <= '0;
            if (!div_ready_c) missed <= 1'b1;
          end else begin
            sum   <= sum_next_c;
            count <= count_inc_c;
          end
        end
        if (div_done) begin
          mean       <= quotient;
          mean_valid <= 1'b1;
        end
      end
    end
  end

  seq_divider #(
    .WIDTH (DIV_W),
    .DVS_W (LEN_W),
    .Q_W   (IN_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .start    (div_start_c),
    .dividend (dividend_c),
    .divisor  (eff_len_c),
    .quotient (quotient),
    .done     (div_done),
    .busy     (div_busy)
  );

  assign busy = div_busy;

endmodule

// File: tb/tb_windowed_mean.sv
// Scoreboard bench for windowed_mean: a window-level model queues expected means and
// missed pulses with their due cycles; a negedge monitor pops and compares.
module tb_windowed_mean;

`ifdef WINDOWED_MEAN_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int DIV_W = 48 + RND;
  localparam int LAT   = DIV_W + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] period = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] mean;
  logic        mean_valid, busy, missed;

  windowed_mean dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .period(period), .in_valid(in_valid),
    .in_data(in_data), .mean(mean), .mean_valid(mean_valid), .busy(busy), .missed(missed)
  );

  always #5 clk = ~clk;

  typedef struct { longint val; longint due; } exp_t;
  exp_t   exp_q[$];
  longint miss_q[$];
  longint win[$];
  longint wlen = 0;
  longint last_acc = -1000;
  longint last_mean = 0;
  longint cyc = 0;
  int     ntests = 0;
  int     nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    ntests++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    miss_q.delete();
    win.delete();
    wlen = 0;
    last_acc = -1000;
  endtask

  // Apply one cycle of stimulus and predict its effect at the coming edge e
  task automatic step(input bit v, input logic [31:0] d, input logic [15:0] p, input bit c);
    longint e, s;
    in_valid = v; in_data = d; period = p; clear = c;
    e = cyc + 1;
    if (c) begin
      model_flush();
    end else if (v && !(win.size() == 0 && p == 0)) begin
      if (win.size() == 0) wlen = p;
      win.push_back(longint'(d));
      if (win.size() == wlen) begin
        s = 0;
        foreach (win[i]) s += win[i];
        if (e >= last_acc + LAT) begin
          exp_q.push_back('{val: (s + (RND ? wlen / 2 : 0)) / wlen, due: e + LAT});
          last_acc = e;
        end else begin
          miss_q.push_back(e);
        end
        win.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 16'd0, 1'b0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mean_valid) begin
        if (exp_q.size() == 0) check("spurious_mean_valid", 1, 0);
        else begin
          check("mean_value", mean, exp_q[0].val);
          check("mean_latency", cyc, exp_q[0].due);
          last_mean = exp_q[0].val;
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        check("mean_valid_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      if (missed) begin
        if (miss_q.size() == 0) check("spurious_missed", 1, 0);
        else begin
          check("missed_cycle", cyc, miss_q[0]);
          void'(miss_q.pop_front());
        end
      end else if (miss_q.size() > 0 && cyc > miss_q[0]) begin
        check("missed_absent", 0, 1);
        void'(miss_q.pop_front());
      end
      if (!mean_valid && mean != 32'(last_mean)) check("mean_hold", mean, last_mean);
    end
  end

  initial begin
    #2;
    check("rst_mean", mean, 0);
    check("rst_mean_valid", mean_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", missed, 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic window
    step(1, 10, 4, 0); step(1, 20, 4, 0); step(1, 30, 4, 0); step(1, 40, 4, 0);
    check("busy_after_end", busy, 1);
    idle(LAT + 3);
    // Rounding case: 7/4
    step(1, 1, 4, 0); step(1, 2, 4, 0); step(1, 2, 4, 0); step(1, 2, 4, 0);
    idle(LAT + 3);
    // period=1 back to back: first accepted, next two missed
    step(1, 77, 1, 0); step(1, 5, 1, 0); step(1, 6, 1, 0);
    idle(LAT + 3);
    // Gapped input with mid-window period change
    step(1, 3, 3, 0); idle(2);
    step(1, 6, 2, 0); idle(2);
    step(1, 9, 2, 0); idle(2);
    step(1, 5, 2, 0); step(1, 7, 2, 0);
    idle(LAT + 3);
    // Clear mid-window, including a divider in flight
    step(1, 100, 2, 0); step(1, 200, 2, 0);
    step(1, 1, 4, 0); step(1, 2, 4, 0);
    step(1, 3, 4, 1);
    step(1, 4, 4, 0); step(1, 4, 4, 0); step(1, 4, 4, 0); step(1, 4, 4, 0);
    idle(LAT + 3);
    // period=0 never opens a window
    for (int i = 0; i < 6; i++) step(1, 32'(i + 50), 0, 0);
    idle(LAT + 3);
    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 16'($urandom_range(0, 6)),
           ($urandom_range(0, 49) == 0));
    idle(LAT + 3);
    // Asynchronous reset while the divider runs
    step(1, 9, 2, 0); step(1, 11, 2, 0);
    idle(10);
    rst_n = 1'b0;
    model_flush();
    last_mean = 0;
    #1;
    check("rst_run_mean", mean, 0);
    check("rst_run_mean_valid", mean_valid, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_missed", missed, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(LAT + 3);
    // Full-scale window, no overflow
    for (int i = 0; i < 65535; i++) step(1, 32'hFFFF_FFFF, 16'hFFFF, 0);
    idle(LAT + 3);
    check("final_mean", mean, 32'hFFFF_FFFF);
    check("exp_queue_drained", exp_q.size(), 0);
    check("miss_queue_drained", miss_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
